// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment encoders and the capture monitor.
// Segment patterns are active-low, bits 6:0 = g..a, decimal point excluded.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      LOCKED
   } seg7_state_e;

   // Forward table used by the encoders; the decoder searches it in reverse.
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         4'hF:    seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the segment encoder table.
// Ports:
//   seg_i    [6:0]  active-low segment pattern (g..a), DP stripped
//   hit_o           pattern matches one of the 16 digit glyphs
//   blank_o         pattern is all segments off
//   value_o  [3:0]  matched digit, 0 when no hit
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic       hit_o,
   output logic       blank_o,
   output logic [3:0] value_o
);

   always_comb begin
      hit_o   = 1'b0;
      value_o = 4'h0;
      blank_o = (seg_i == SEG_BLANK);
      for (int i = 0; i < 16; i++) begin
         if (seg_i == seg_encode(4'(i))) begin
            hit_o   = 1'b1;
            value_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_capture.sv
// Display monitor: recovers the hex digit shown on an active-low 7-segment bus.
// A pattern is accepted once the same 8-bit value has been sampled on
// STABLE_CYCLES consecutive edges; results register on the following edge.
// Ports:
//   CLOCK_50          system clock, rising edge
//   RESET_N           asynchronous active-low reset
//   HEX_IN    [7:0]   segment bus, active-low, bit7 = DP
//   DIGIT     [3:0]   last accepted valid digit
//   DP                decimal point of last accepted pattern (1 = lit)
//   VALID             last accepted pattern decoded to a digit
//   BLANK             last accepted pattern was all segments off
//   ERROR             last accepted pattern was neither blank nor a digit
//   UPDATE            one-cycle pulse when a new pattern is accepted
//   UPD_COUNT [CNT_W-1:0]  UPDATE pulse count, wraps
//
// state  | meaning
// IDLE   | nothing sampled since reset
// SETTLE | waiting for the bus to hold one value long enough
// LOCKED | bus equals the accepted value
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [7:0]       HEX_IN,
   output logic [3:0]       DIGIT,
   output logic             DP,
   output logic             VALID,
   output logic             BLANK,
   output logic             ERROR,
   output logic             UPDATE,
   output logic [CNT_W-1:0] UPD_COUNT
);

   localparam int               STB_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

   seg7_state_e      state_q, state_d;
   logic [7:0]       hex_q;
   logic [7:0]       acc_q, acc_d;
   logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
   logic [3:0]       digit_q, digit_d;
   logic             dp_q, dp_d;
   logic             valid_q, valid_d;
   logic             blank_q, blank_d;
   logic             error_q, error_d;
   logic             update_d, update_q;
   logic [CNT_W-1:0] upd_cnt_q, upd_cnt_d;

   logic             dec_hit;
   logic             dec_blank;
   logic [3:0]       dec_value;
   logic             same;
   logic             have_acc;

   seg7_pattern_decode u_decode (
      .seg_i   (hex_q[6:0]),
      .hit_o   (dec_hit),
      .blank_o (dec_blank),
      .value_o (dec_value)
   );

   // hex_q is the previous sample; stb_cnt_q counts repeats of it, so a value
   // of STABLE_CYCLES-1 means hex_q has been seen on STABLE_CYCLES edges.
   assign same     = (HEX_IN == hex_q);
   // acc_q is only meaningful once something has been accepted.
   assign have_acc = valid_q | blank_q | error_q;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      digit_d   = digit_q;
      dp_d      = dp_q;
      valid_d   = valid_q;
      blank_d   = blank_q;
      error_d   = error_q;
      update_d  = 1'b0;
      upd_cnt_d = upd_cnt_q;

      if (!same) begin
         stb_cnt_d = '0;
      end else if (stb_cnt_q == STB_LAST) begin
         stb_cnt_d = stb_cnt_q;
      end else begin
         stb_cnt_d = stb_cnt_q + STB_W'(1);
      end

      case (state_q)
         IDLE: begin
            state_d   = SETTLE;
            stb_cnt_d = '0;
         end
         SETTLE: begin
            if (stb_cnt_q == STB_LAST) begin
               // Settling back onto the held value is a glitch, not an update.
               if (!have_acc || (hex_q != acc_q)) begin
                  acc_d     = hex_q;
                  update_d  = 1'b1;
                  upd_cnt_d = upd_cnt_q + CNT_W'(1);
                  dp_d      = ~hex_q[7];
                  if (dec_hit) begin
                     digit_d = dec_value;
                     valid_d = 1'b1;
                     blank_d = 1'b0;
                     error_d = 1'b0;
                  end else if (dec_blank) begin
                     valid_d = 1'b0;
                     blank_d = 1'b1;
                     error_d = 1'b0;
                  end else begin
                     valid_d = 1'b0;
                     blank_d = 1'b0;
                     error_d = 1'b1;
                  end
               end
               // The bus may already have moved on during the accept edge.
               state_d = same ? LOCKED : SETTLE;
            end
         end
         LOCKED: begin
            if (HEX_IN != acc_q) begin
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         hex_q     <= '0;
         acc_q     <= '0;
         stb_cnt_q <= '0;
         digit_q   <= '0;
         dp_q      <= 1'b0;
         valid_q   <= 1'b0;
         blank_q   <= 1'b0;
         error_q   <= 1'b0;
         update_q  <= 1'b0;
         upd_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hex_q     <= HEX_IN;
         acc_q     <= acc_d;
         stb_cnt_q <= stb_cnt_d;
         digit_q   <= digit_d;
         dp_q      <= dp_d;
         valid_q   <= valid_d;
         blank_q   <= blank_d;
         error_q   <= error_d;
         update_q  <= update_d;
         upd_cnt_q <= upd_cnt_d;
      end
   end

   assign DIGIT     = digit_q;
   assign DP        = dp_q;
   assign VALID     = valid_q;
   assign BLANK     = blank_q;
   assign ERROR     = error_q;
   assign UPDATE    = update_q;
   assign UPD_COUNT = upd_cnt_q;

endmodule
